// File: rtl/sram_burst_ctrl_if.sv
// Command / write-stream / read-stream bundle of the SRAM burst controller.
// The controller takes the slave side; the command source and data consumer take the master side.
interface sram_burst_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [18:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [1:0]       cmd_be;
  logic             wr_valid;
  logic             wr_ready;
  logic [15:0]      wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [15:0]      rd_data;
  logic             rd_last;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
    input  wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
    output wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst request controller in front of the ICOBOARD SRAM pin-access stage: one access slot per
// clk cycle, sram_* driven from registers, read words captured into a small FIFO with backpressure.
module sram_burst_ctrl #(
  parameter int LEN_W      = 8,
  parameter int RBUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_burst_ctrl_if.slave     bus,
  output logic [18:0]          sram_address,
  output logic                 sram_write_enable,
  output logic                 sram_lower_byte,
  output logic                 sram_upper_byte,
  output logic [15:0]          sram_write_data,
  input  logic [15:0]          sram_read_data
);

  localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam int CW = $clog2(RBUF_DEPTH + 1);
  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [CW:0]      OCC_LIMIT = (CW + 1)'(RBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t           state;
  logic [18:0]      cur_addr;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       be;
  logic             in_flight;
  logic             in_flight_last;

  logic [15:0]      buf_data [RBUF_DEPTH];
  logic             buf_last [RBUF_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             pop;
  logic             push;
  logic [CW:0]      occ;
  logic             room;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(RBUF_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign pop  = (count != {CW{1'b0}}) && bus.rd_ready;
  assign push = in_flight;

  // A new read slot is allowed only if its word is guaranteed a free entry when it lands.
  always_comb begin
    occ  = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, in_flight};
    room = (occ < OCC_LIMIT);
  end

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = (count != {CW{1'b0}});
  assign bus.rd_data   = buf_data[head];
  assign bus.rd_last   = buf_last[head];
  assign bus.busy      = (state != IDLE) || (count != {CW{1'b0}}) || in_flight;

  // Burst FSM and SRAM slot registers; every cycle defaults to a bubble slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cur_addr          <= 19'd0;
      remaining         <= LEN_ZERO;
      be                <= 2'b00;
      in_flight         <= 1'b0;
      in_flight_last    <= 1'b0;
      sram_address      <= 19'd0;
      sram_write_enable <= 1'b0;
      sram_lower_byte   <= 1'b0;
      sram_upper_byte   <= 1'b0;
      sram_write_data   <= 16'd0;
    end else begin
      in_flight         <= 1'b0;
      in_flight_last    <= 1'b0;
      sram_write_enable <= 1'b0;
      sram_lower_byte   <= 1'b0;
      sram_upper_byte   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            be <= bus.cmd_be;
            if (bus.cmd_write) begin
              cur_addr  <= bus.cmd_addr;
              remaining <= bus.cmd_len;
              state     <= WRITE;
            end else if (room) begin
              // First read slot goes out on the handshake edge itself.
              sram_address    <= bus.cmd_addr;
              sram_lower_byte <= 1'b1;
              sram_upper_byte <= 1'b1;
              in_flight       <= 1'b1;
              in_flight_last  <= (bus.cmd_len == LEN_ZERO);
              cur_addr        <= bus.cmd_addr + 19'd1;
              remaining       <= bus.cmd_len - LEN_ONE;
              state           <= (bus.cmd_len == LEN_ZERO) ? IDLE : READ;
            end else begin
              cur_addr  <= bus.cmd_addr;
              remaining <= bus.cmd_len;
              state     <= READ;
            end
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            sram_address      <= cur_addr;
            sram_write_data   <= bus.wr_data;
            sram_write_enable <= 1'b1;
            sram_lower_byte   <= be[0];
            sram_upper_byte   <= be[1];
            cur_addr          <= cur_addr + 19'd1;
            remaining         <= remaining - LEN_ONE;
            if (remaining == LEN_ZERO) begin
              state <= IDLE;
            end
          end
        end
        READ: begin
          if (room) begin
            sram_address    <= cur_addr;
            sram_lower_byte <= 1'b1;
            sram_upper_byte <= 1'b1;
            in_flight       <= 1'b1;
            in_flight_last  <= (remaining == LEN_ZERO);
            cur_addr        <= cur_addr + 19'd1;
            remaining       <= remaining - LEN_ONE;
            if (remaining == LEN_ZERO) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read buffer: the in-flight word lands at the edge closing its slot, independent of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= {PW{1'b0}};
      tail  <= {PW{1'b0}};
      count <= {CW{1'b0}};
      for (int i = 0; i < RBUF_DEPTH; i++) begin
        buf_data[i] <= 16'd0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data[tail] <= sram_read_data;
        buf_last[tail] <= in_flight_last;
        tail           <= ptr_next(tail);
      end
      if (pop) begin
        head <= ptr_next(head);
      end
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: table of burst commands driven through a scoreboard, with a
// behavioural SRAM behind the pin signals and hand-written reset / idle sequences.
module tb_sram_burst_ctrl;
  localparam int LEN_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] sram_address;
  logic        sram_write_enable;
  logic        sram_lower_byte;
  logic        sram_upper_byte;
  logic [15:0] sram_write_data;
  logic [15:0] sram_read_data;

  sram_burst_ctrl_if #(.LEN_W(LEN_W)) bus ();

  sram_burst_ctrl #(.LEN_W(LEN_W), .RBUF_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .sram_address      (sram_address),
    .sram_write_enable (sram_write_enable),
    .sram_lower_byte   (sram_lower_byte),
    .sram_upper_byte   (sram_upper_byte),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  len;
    logic [1:0]  be;
    logic        gappy;
    int          rd_mode;   // 0 always ready, 1 stall 5 after first word, 2 random
    logic [15:0] seed;
    logic [15:0] step;
    int          exp_beats;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] sram_mem [0:524287];
  logic [15:0] ref_mem  [0:524287];
  logic [36:0] exp_wr [$];
  logic [16:0] exp_rd [$];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   c0 = 0;
  int   wr_seen = 0;
  int   rd_seen = 0;
  int   first_rd_cyc = 0;
  int   last_rd_cyc = 0;
  logic first_pending = 1'b0;

  assign sram_read_data = sram_mem[sram_address];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired, got no completion, required completion", name);
  endtask

  // SRAM model (writes in the low phase) and scoreboard consumer, sampled at negedge.
  initial begin
    logic [36:0] e;
    logic [16:0] r;
    for (int i = 0; i < 524288; i++) sram_mem[i] = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sram_write_enable) begin
          if (exp_wr.size() == 0) begin
            check("wr_slot_unexpected", {1'b1, 44'd0, sram_address}, 64'd0);
          end else begin
            e = exp_wr.pop_front();
            check("wr_slot", {27'd0, sram_address, sram_write_data, sram_upper_byte, sram_lower_byte},
                  {27'd0, e});
          end
          wr_seen++;
          if (sram_lower_byte) sram_mem[sram_address][7:0]  = sram_write_data[7:0];
          if (sram_upper_byte) sram_mem[sram_address][15:8] = sram_write_data[15:8];
        end
        if (bus.rd_valid && first_pending) begin
          check("rd_latency", 64'(cyc - c0), 64'd2);
          first_pending = 1'b0;
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_rd.size() == 0) begin
            check("rd_word_unexpected", {1'b1, 46'd0, bus.rd_data, bus.rd_last}, 64'd0);
          end else begin
            r = exp_rd.pop_front();
            check("rd_word", {47'd0, bus.rd_data, bus.rd_last}, {47'd0, r});
          end
          if (rd_seen == 0) first_rd_cyc = cyc;
          last_rd_cyc = cyc;
          rd_seen++;
        end
      end
    end
  end

  task automatic issue_cmd(input vec_t v, output int ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_be    = v.be;
    ok = 0;
    for (int t = 0; t < 50 && ok == 0; t++) begin
      if (bus.cmd_ready) begin
        c0 = cyc;
        if (!v.wr) first_pending = 1'b1;
        ok = 1;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (ok == 0) fail_now("cmd_handshake");
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    check("idle_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("idle_we", {63'd0, sram_write_enable}, 64'd0);
  endtask

  task automatic run_write(input vec_t v);
    int          ok;
    int          beat;
    int          t;
    logic        phase;
    logic        acc;
    logic [18:0] a;
    logic [15:0] d;
    wr_seen = 0;
    issue_cmd(v, ok);
    if (ok != 0) begin
      beat = 0; t = 0; phase = 1'b0;
      while (beat <= int'(v.len) && t < 4000) begin
        d = v.seed + 16'(beat) * v.step;
        if (!phase) begin
          bus.wr_valid = 1'b1; bus.wr_data = d;
        end else begin
          bus.wr_valid = 1'b0; bus.wr_data = 16'hDEAD;
        end
        acc = bus.wr_valid && bus.wr_ready;
        if (acc) begin
          a = v.addr + 19'(beat);
          exp_wr.push_back({a, d, v.be[1], v.be[0]});
          if (v.be[0]) ref_mem[a][7:0]  = d[7:0];
          if (v.be[1]) ref_mem[a][15:8] = d[15:8];
        end
        @(posedge clk); #1;
        if (acc) beat++;
        if (v.gappy) phase = ~phase;
        t++;
      end
      bus.wr_valid = 1'b0;
      if (beat <= int'(v.len)) fail_now("wr_beats");
    end
    settle();
    check("wr_slot_count", 64'(wr_seen), 64'(v.exp_beats));
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic run_read(input vec_t v);
    int          ok;
    int          t;
    int          stall_left;
    logic [18:0] a;
    logic [15:0] hold;
    rd_seen = 0;
    hold = 16'h0000;
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + 19'(i);
      exp_rd.push_back({ref_mem[a], (i == int'(v.len))});
    end
    bus.rd_ready = 1'b1;
    issue_cmd(v, ok);
    if (ok != 0) begin
      t = 0; stall_left = 5;
      while (rd_seen < v.exp_beats && t < 4000) begin
        case (v.rd_mode)
          1: begin
            if (rd_seen >= 1 && stall_left > 0) begin
              bus.rd_ready = 1'b0;
              if (stall_left == 5) hold = bus.rd_data;
              else check("rd_hold", {47'd0, bus.rd_valid, bus.rd_data}, {47'd0, 1'b1, hold});
              stall_left--;
            end else begin
              bus.rd_ready = 1'b1;
            end
          end
          2: bus.rd_ready = 1'($urandom_range(0, 1));
          default: bus.rd_ready = 1'b1;
        endcase
        @(posedge clk); #1;
        t++;
      end
      bus.rd_ready = 1'b1;
      if (rd_seen < v.exp_beats) fail_now("rd_beats");
    end
    settle();
    check("rd_word_count", 64'(rd_seen), 64'(v.exp_beats));
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    if (v.rd_mode == 0) check("rd_stream", 64'(last_rd_cyc - first_rd_cyc), 64'(v.len));
  endtask

  initial begin
    vec_t rv;
    int   t;
    int   ok;
    vecs[0] = '{1'b1, 19'h00010, 8'd3,   2'b11, 1'b0, 0, 16'h1111, 16'h1111, 4};
    vecs[1] = '{1'b0, 19'h00010, 8'd3,   2'b00, 1'b0, 0, 16'h0000, 16'h0000, 4};
    vecs[2] = '{1'b0, 19'h00010, 8'd3,   2'b00, 1'b0, 1, 16'h0000, 16'h0000, 4};
    vecs[3] = '{1'b1, 19'h7FFFE, 8'd2,   2'b01, 1'b1, 0, 16'hA5C3, 16'h0101, 3};
    vecs[4] = '{1'b0, 19'h7FFFE, 8'd2,   2'b00, 1'b0, 0, 16'h0000, 16'h0000, 3};
    vecs[5] = '{1'b0, 19'h00011, 8'd0,   2'b00, 1'b0, 0, 16'h0000, 16'h0000, 1};
    vecs[6] = '{1'b1, 19'h00200, 8'd255, 2'b10, 1'b0, 0, 16'h1234, 16'h0301, 256};
    vecs[7] = '{1'b0, 19'h00200, 8'd255, 2'b00, 1'b0, 2, 16'h0000, 16'h0000, 256};
    for (int i = 0; i < 524288; i++) ref_mem[i] = 16'h0000;

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 19'd0;
    bus.cmd_len = 8'd0; bus.cmd_be = 2'b00;
    bus.wr_valid = 1'b0; bus.wr_data = 16'h0000; bus.rd_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sram_pins", {26'd0, sram_address, sram_write_enable, sram_lower_byte, sram_upper_byte, sram_write_data}, 64'd0);
    check("rst_rd_outputs", {46'd0, bus.rd_valid, bus.rd_last, bus.rd_data}, 64'd0);
    check("rst_ready_busy", {61'd0, bus.cmd_ready, bus.wr_ready, bus.busy}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

    // Stray write beats outside WRITE must not be taken.
    bus.wr_valid = 1'b1; bus.wr_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
    end
    bus.wr_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) run_write(vecs[i]);
      else run_read(vecs[i]);
    end

    // Reset in the middle of an 8-beat read, after two words were delivered.
    rv = '{1'b0, 19'h00010, 8'd7, 2'b00, 1'b0, 0, 16'h0000, 16'h0000, 8};
    rd_seen = 0;
    for (int i = 0; i < 8; i++) exp_rd.push_back({ref_mem[19'h00010 + 19'(i)], (i == 7)});
    bus.rd_ready = 1'b1;
    issue_cmd(rv, ok);
    t = 0;
    while (rd_seen < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (rd_seen < 2) fail_now("rst_mid_wait");
    rst = 1'b1;
    #1;
    check("rst_mid_we", {63'd0, sram_write_enable}, 64'd0);
    check("rst_mid_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
    exp_rd.delete();
    first_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_release_ready", {63'd0, bus.cmd_ready}, 64'd1);
    run_read('{1'b0, 19'h00013, 8'd0, 2'b00, 1'b0, 0, 16'h0000, 16'h0000, 1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
